spi_master: RTL and testbench

Single-channel SPI master that issues one 16-bit transaction per request to the SPI slave memory: 7-bit address, 1 R/W bit, 8 data bits. It sits on the system-clock side. It converts a parallel request/done handshake into `cs_n`/`sclk`/`mosi` and captures `miso` into parallel read data. The frame format matches the slave's: address phase, then RW bit (1 = read, 0 = write), then data phase, MSB first.

---
 rtl/spi_pkg.sv | 27 ++
 rtl/spi_clk_div.sv | 37 +++
 rtl/spi_master.sv | 150 +++++++++++++++
 tb/tb_spi_master.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI master: FSM states, frame geometry
// and the helper that builds the 16-bit frame.
package spi_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_SHIFT,
    ST_HOLD,
    ST_GAP
  } spi_state_e;

  localparam int   SPI_ADDR_W  = 7;
  localparam int   SPI_DATA_W  = 8;
  localparam int   SPI_FRAME_W = 16;
  localparam logic SPI_RW_READ = 1'b1;

  // Reads shift zeros in the data phase so the slave never sees stale wdata.
  function automatic logic [SPI_FRAME_W-1:0] spi_frame(
    input logic [SPI_ADDR_W-1:0] addr,
    input logic                  rw,
    input logic [SPI_DATA_W-1:0] wdata
  );
    return {addr, rw, (rw == SPI_RW_READ) ? {SPI_DATA_W{1'b0}} : wdata};
  endfunction

endpackage

// File: rtl/spi_clk_div.sv
// Half-period counter for sclk: emits a one-cycle tick every CLK_DIV enabled
// clk cycles, restarting from zero on clear.
module spi_clk_div #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic en,
  output logic tick
);

  localparam logic [7:0] TICK_AT = 8'(CLK_DIV - 1);

  logic [7:0] cnt_q;
  logic [7:0] cnt_d;

  assign tick = en && (cnt_q == TICK_AT);

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = 8'd0;
    end else if (en) begin
      cnt_d = tick ? 8'd0 : cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= 8'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/spi_master.sv
// SPI mode-0 master: turns a start/done request into one 16-bit frame
// (7-bit address, RW bit, 8 data bits, MSB first) and returns read data.
module spi_master
  import spi_pkg::*;
#(
  parameter int CLK_DIV = 4,
  parameter int CS_GAP  = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  rw,
  input  logic [SPI_ADDR_W-1:0] addr,
  input  logic [SPI_DATA_W-1:0] wdata,
  output logic                  busy,
  output logic                  done,
  output logic [SPI_DATA_W-1:0] rdata,
  output logic                  cs_n,
  output logic                  sclk,
  output logic                  mosi,
  input  logic                  miso
);

  localparam logic [7:0] GAP_LAST  = 8'(CS_GAP - 1);
  localparam logic [4:0] FRAME_LEN = 5'(SPI_FRAME_W);

  spi_state_e             state_q;
  logic [SPI_FRAME_W-1:0] tx_q;
  logic [SPI_DATA_W-1:0]  rx_q;
  logic                   rw_q;
  logic [4:0]             bit_cnt_q;
  logic [7:0]             gap_cnt_q;
  logic                   busy_q;
  logic                   done_q;
  logic [SPI_DATA_W-1:0]  rdata_q;
  logic                   cs_n_q;
  logic                   sclk_q;
  logic                   mosi_q;

  logic                   accept;
  logic                   div_en;
  logic                   tick;
  logic [SPI_FRAME_W-1:0] tx_d;

  // Acceptance looks at registered busy, so a start in the cycle busy falls waits one cycle.
  always_comb begin
    accept = (state_q == ST_IDLE) && !busy_q && start;
    div_en = (state_q == ST_SETUP) || (state_q == ST_SHIFT) || (state_q == ST_HOLD);
    tx_d   = spi_frame(addr, rw, wdata);
  end

  spi_clk_div #(
    .CLK_DIV(CLK_DIV)
  ) u_clk_div (
    .clk  (clk),
    .rst_n(rst_n),
    .clear(accept),
    .en   (div_en),
    .tick (tick)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      tx_q      <= '0;
      rx_q      <= '0;
      rw_q      <= 1'b0;
      bit_cnt_q <= 5'd0;
      gap_cnt_q <= 8'd0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      rdata_q   <= '0;
      cs_n_q    <= 1'b1;
      sclk_q    <= 1'b0;
      mosi_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            tx_q      <= tx_d;
            rw_q      <= rw;
            bit_cnt_q <= 5'd0;
            busy_q    <= 1'b1;
            cs_n_q    <= 1'b0;
            mosi_q    <= tx_d[SPI_FRAME_W-1];
            state_q   <= ST_SETUP;
          end
        end
        ST_SETUP: begin
          if (tick) begin
            sclk_q    <= 1'b1;
            rx_q      <= (rx_q << 1) | {{(SPI_DATA_W-1){1'b0}}, miso};
            bit_cnt_q <= bit_cnt_q + 5'd1;
            state_q   <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          if (tick) begin
            if (!sclk_q) begin
              sclk_q    <= 1'b1;
              rx_q      <= (rx_q << 1) | {{(SPI_DATA_W-1){1'b0}}, miso};
              bit_cnt_q <= bit_cnt_q + 5'd1;
            end else begin
              sclk_q <= 1'b0;
              // The falling edge after the last rising edge only closes the frame.
              if (bit_cnt_q < FRAME_LEN) begin
                tx_q   <= tx_q << 1;
                mosi_q <= tx_q[SPI_FRAME_W-2];
              end else begin
                state_q <= ST_HOLD;
              end
            end
          end
        end
        ST_HOLD: begin
          if (tick) begin
            cs_n_q    <= 1'b1;
            done_q    <= 1'b1;
            mosi_q    <= 1'b0;
            gap_cnt_q <= 8'd0;
            if (rw_q == SPI_RW_READ) begin
              rdata_q <= rx_q;
            end
            state_q <= ST_GAP;
          end
        end
        ST_GAP: begin
          if (gap_cnt_q == GAP_LAST) begin
            busy_q  <= 1'b0;
            state_q <= ST_IDLE;
          end else begin
            gap_cnt_q <= gap_cnt_q + 8'd1;
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy  = busy_q;
  assign done  = done_q;
  assign rdata = rdata_q;
  assign cs_n  = cs_n_q;
  assign sclk  = sclk_q;
  assign mosi  = mosi_q;

endmodule

// File: tb/tb_spi_master.sv
// Bench for spi_master: two instances (default timing and CLK_DIV=2/CS_GAP=1)
// driven with directed and random frames against a frame-level reference.
module tb_spi_master;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start [2];
  logic       rw    [2];
  logic [6:0] addr  [2];
  logic [7:0] wdata [2];
  logic       busy  [2];
  logic       done  [2];
  logic [7:0] rdata [2];
  logic       cs_n  [2];
  logic       sclk  [2];
  logic       mosi  [2];
  logic       miso  [2];

  int total = 0;
  int bad   = 0;

  logic [7:0] exp_rdata [2];
  logic       nxt_rw;
  logic [6:0] nxt_addr;
  logic [7:0] nxt_wdata;

  always #5 clk = ~clk;

  spi_master #(.CLK_DIV(4), .CS_GAP(2)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start[0]), .rw(rw[0]), .addr(addr[0]),
    .wdata(wdata[0]), .busy(busy[0]), .done(done[0]), .rdata(rdata[0]),
    .cs_n(cs_n[0]), .sclk(sclk[0]), .mosi(mosi[0]), .miso(miso[0])
  );

  spi_master #(.CLK_DIV(2), .CS_GAP(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start[1]), .rw(rw[1]), .addr(addr[1]),
    .wdata(wdata[1]), .busy(busy[1]), .done(done[1]), .rdata(rdata[1]),
    .cs_n(cs_n[1]), .sclk(sclk[1]), .mosi(mosi[1]), .miso(miso[1])
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Runs one frame on unit u, entered at a negedge with the unit idle.
  // Cycle n is the clk period following the n-th edge after the accept edge.
  task automatic run_frame(input int u, input logic r, input logic [6:0] a,
                           input logic [7:0] w, input logic [15:0] resp,
                           input int abort_n, input bit mid_pulses, input bit tail_start);
    int          d        = (u == 0) ? 4 : 2;
    int          g        = (u == 0) ? 2 : 1;
    int          last     = 1 + 33 * d + g;
    logic [15:0] exp_tx   = {a, r, (r ? 8'h00 : w)};
    logic [15:0] got_tx   = 16'h0;
    int          rises    = 0;
    int          rise_bad = 0;
    int          done_cnt = 0;
    int          done_n   = -1;
    int          busy_low = -1;
    int          cs_hi_in = 0;
    int          cs_hi_gap = 0;
    logic        prev_sclk = 1'b0;
    logic [7:0]  rd_at_done = 8'h00;

    start[u] = 1'b1;
    rw[u]    = r;
    addr[u]  = a;
    wdata[u] = w;
    @(posedge clk);
    for (int n = 1; n <= last; n++) begin
      @(negedge clk);
      if (n == 1) start[u] = 1'b0;
      if (mid_pulses && n == 50) begin
        start[u] = 1'b1;
        rw[u]    = ~r;
        addr[u]  = ~a;
      end
      if (mid_pulses && n == 51) start[u] = 1'b0;
      if (tail_start && n == last - 1) begin
        start[u] = 1'b1;
        rw[u]    = nxt_rw;
        addr[u]  = nxt_addr;
        wdata[u] = nxt_wdata;
      end
      if (n == abort_n) begin
        rst_n = 1'b0;
        #1;
        check_val("rst_async", {cs_n[u], sclk[u], mosi[u], busy[u], done[u], rdata[u]},
                  {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00});
        for (int k = 0; k < 3; k++) begin
          @(negedge clk);
          check_val("rst_nodone", {31'd0, done[u]}, 32'd0);
        end
        rst_n = 1'b1;
        exp_rdata[0] = 8'h00;
        exp_rdata[1] = 8'h00;
        return;
      end
      if (n == 1) begin
        check_val("first_cycle", {cs_n[u], busy[u], mosi[u]}, {1'b0, 1'b1, a[6]});
        miso[u] = resp[15];
      end
      if (!prev_sclk && sclk[u]) begin
        rises++;
        got_tx = {got_tx[14:0], mosi[u]};
        if (n != 1 + (2 * rises - 1) * d) rise_bad++;
      end
      if (prev_sclk && !sclk[u] && rises < 16) miso[u] = resp[15 - rises];
      prev_sclk = sclk[u];
      if (done[u]) begin
        done_cnt++;
        done_n = n;
        rd_at_done = rdata[u];
      end
      if (cs_n[u] && n < 1 + 33 * d) cs_hi_in++;
      if (cs_n[u] && n >= 1 + 33 * d) cs_hi_gap++;
      if (!busy[u] && busy_low < 0) busy_low = n;
    end
    if (r) exp_rdata[u] = resp[7:0];
    check_val("rise_count", rises, 16);
    check_val("rise_timing", rise_bad, 0);
    check_val("mosi_frame", {16'h0, got_tx}, {16'h0, exp_tx});
    check_val("done_count", done_cnt, 1);
    check_val("done_cycle", done_n, 1 + 33 * d);
    check_val("rdata_at_done", {24'h0, rd_at_done}, {24'h0, exp_rdata[u]});
    check_val("cs_low_frame", cs_hi_in, 0);
    check_val("cs_high_gap", cs_hi_gap, g + 1);
    check_val("busy_low_cycle", busy_low, last);
    check_val("rdata_hold", {24'h0, rdata[u]}, {24'h0, exp_rdata[u]});
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    for (int u = 0; u < 2; u++) begin
      start[u] = 1'b0;
      rw[u]    = 1'b0;
      addr[u]  = 7'h00;
      wdata[u] = 8'h00;
      miso[u]  = 1'b0;
      exp_rdata[u] = 8'h00;
    end
    repeat (3) @(negedge clk);
    for (int u = 0; u < 2; u++) begin
      check_val("reset_state", {cs_n[u], sclk[u], mosi[u], busy[u], done[u], rdata[u]},
                {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00});
    end
    rst_n = 1'b1;
    @(negedge clk);

    run_frame(0, 1'b0, 7'h2A, 8'h55, 16'($urandom), 0, 1'b0, 1'b0);
    run_frame(0, 1'b1, 7'h7F, 8'h3C, {8'($urandom), 8'hA5}, 0, 1'b0, 1'b0);

    // Ignored pulses mid-frame and at cycle 134; the held start lands on cycle 135.
    nxt_rw    = 1'b1;
    nxt_addr  = 7'($urandom);
    nxt_wdata = 8'($urandom);
    run_frame(0, 1'b0, 7'h11, 8'hC3, 16'($urandom), 0, 1'b1, 1'b1);
    run_frame(0, nxt_rw, nxt_addr, nxt_wdata, 16'($urandom), 60, 1'b0, 1'b0);
    run_frame(0, 1'b1, 7'($urandom), 8'($urandom), 16'($urandom), 0, 1'b0, 1'b0);

    run_frame(1, 1'b1, 7'($urandom), 8'($urandom), 16'($urandom), 0, 1'b0, 1'b0);
    run_frame(1, 1'b1, 7'($urandom), 8'($urandom), 16'($urandom), 0, 1'b0, 1'b0);

    for (int i = 0; i < 8; i++) begin
      run_frame($urandom_range(0, 1), 1'($urandom), 7'($urandom), 8'($urandom),
                16'($urandom), 0, 1'b0, 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
